// File: rtl/nonstd_caller.sv
// nonstd_caller: host-driven initiator for the nonstd __start/__valid/__idle
// call handshake. One host request issues a run of back-to-back calls with a
// shared argument, sums the callee latency and aborts the run on a per-call
// timeout. All outputs come straight from registers.
module nonstd_caller #(
  parameter int unsigned ARG_W   = 32,
  parameter int unsigned CNT_W   = 8,
  parameter logic [31:0] TIMEOUT = 32'hFFFF_FFFF
) (
  input  logic             __clk,
  input  logic             __resetn,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [ARG_W-1:0] req_arg,
  input  logic [CNT_W-1:0] req_count,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [31:0]      rsp_cycles,
  output logic [CNT_W-1:0] rsp_calls,
  output logic             rsp_timeout,
  output logic             tick,
  output logic             __c_start,
  output logic [ARG_W-1:0] __c_p_ms,
  input  logic             __c_valid,
  input  logic             __c_idle
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t             r_state;
  logic               r_req_ready;
  logic [CNT_W-1:0]   r_remaining;
  logic [31:0]        r_lat;
  logic               r_start;
  logic [ARG_W-1:0]   r_p_ms;
  logic               r_rsp_valid;
  logic [31:0]        r_cycles;
  logic [CNT_W-1:0]   r_calls;
  logic               r_timeout;
  logic               r_tick;

  state_t             w_state;
  logic               w_req_ready;
  logic [CNT_W-1:0]   w_remaining;
  logic [31:0]        w_lat;
  logic               w_start;
  logic [ARG_W-1:0]   w_p_ms;
  logic               w_rsp_valid;
  logic [31:0]        w_cycles;
  logic [CNT_W-1:0]   w_calls;
  logic               w_timeout;
  logic               w_tick;
  logic [32:0]        w_sum;
  logic [31:0]        w_lat_inc;
  logic               w_lat_expired;

  // Latency counter helpers: saturating increment and timeout detect.
  always_comb begin
    w_lat_inc     = (r_lat == '1) ? r_lat : r_lat + 32'd1;
    w_lat_expired = (TIMEOUT != 32'd0) && (r_lat == TIMEOUT);
  end

  // Next-state and next-output logic; every registered output is computed here.
  always_comb begin
    w_state     = r_state;
    w_remaining = r_remaining;
    w_lat       = r_lat;
    w_start     = 1'b0;
    w_p_ms      = r_p_ms;
    w_rsp_valid = r_rsp_valid;
    w_cycles    = r_cycles;
    w_calls     = r_calls;
    w_timeout   = r_timeout;
    w_tick      = 1'b0;
    w_sum       = {1'b0, r_cycles} + {1'b0, r_lat};

    case (r_state)
      S_IDLE: begin
        if (req_valid && r_req_ready) begin
          w_p_ms      = req_arg;
          w_remaining = req_count;
          w_cycles    = '0;
          w_calls     = '0;
          w_timeout   = 1'b0;
          if (req_count == '0) begin
            w_state     = S_RESP;
            w_rsp_valid = 1'b1;
          end else begin
            w_state = S_ISSUE;
          end
        end
      end

      // Stale done pulses from an aborted call are dropped here by not looking
      // at __c_valid at all.
      S_ISSUE: begin
        if (__c_idle) begin
          w_start = 1'b1;
          w_lat   = '0;
          w_state = S_WAIT;
        end
      end

      // The first WAIT cycle is the one where the callee samples start, so a
      // done pulse cannot belong to this call yet; lat becomes 1 at that edge,
      // giving latency 1 for a callee that answers on the very next cycle.
      // Valid is tested before the timeout so a coincident done still counts.
      S_WAIT: begin
        if (__c_valid && !r_start) begin
          w_cycles    = w_sum[32] ? '1 : w_sum[31:0];
          w_calls     = r_calls + CNT_W'(1);
          w_tick      = 1'b1;
          w_remaining = r_remaining - CNT_W'(1);
          if (r_remaining == CNT_W'(1)) begin
            w_state     = S_RESP;
            w_rsp_valid = 1'b1;
          end else begin
            w_state = S_ISSUE;
          end
        end else if (w_lat_expired && !r_start) begin
          w_timeout   = 1'b1;
          w_state     = S_RESP;
          w_rsp_valid = 1'b1;
        end else begin
          w_lat = w_lat_inc;
        end
      end

      S_RESP: begin
        if (rsp_ready) begin
          w_rsp_valid = 1'b0;
          w_state     = S_IDLE;
        end
      end

      default: begin
        w_state = S_IDLE;
      end
    endcase

    w_req_ready = (w_state == S_IDLE);
  end

  // State and output registers with asynchronous active-low clear.
  always_ff @(posedge __clk or negedge __resetn) begin
    if (!__resetn) begin
      r_state     <= S_IDLE;
      r_req_ready <= 1'b1;
      r_remaining <= '0;
      r_lat       <= '0;
      r_start     <= 1'b0;
      r_p_ms      <= '0;
      r_rsp_valid <= 1'b0;
      r_cycles    <= '0;
      r_calls     <= '0;
      r_timeout   <= 1'b0;
      r_tick      <= 1'b0;
    end else begin
      r_state     <= w_state;
      r_req_ready <= w_req_ready;
      r_remaining <= w_remaining;
      r_lat       <= w_lat;
      r_start     <= w_start;
      r_p_ms      <= w_p_ms;
      r_rsp_valid <= w_rsp_valid;
      r_cycles    <= w_cycles;
      r_calls     <= w_calls;
      r_timeout   <= w_timeout;
      r_tick      <= w_tick;
    end
  end

  assign req_ready   = r_req_ready;
  assign rsp_valid   = r_rsp_valid;
  assign rsp_cycles  = r_cycles;
  assign rsp_calls   = r_calls;
  assign rsp_timeout = r_timeout;
  assign tick        = r_tick;
  assign __c_start   = r_start;
  assign __c_p_ms    = r_p_ms;

endmodule

// File: tb/tb_nonstd_caller.sv
// Bench for nonstd_caller: an ms-sleep style callee (latency = arg*div + 1)
// drives the DUT; a run-level arithmetic model predicts each response, and a
// per-cycle monitor checks handshake rules and output stability.
module tb_nonstd_caller;

  localparam int unsigned TO = 40;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] req_arg = '0;
  logic [7:0]  req_count = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_cycles;
  logic [7:0]  rsp_calls;
  logic        rsp_timeout;
  logic        tick;
  logic        c_start;
  logic [31:0] c_p_ms;
  logic        c_valid;
  logic        c_idle;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  nonstd_caller #(.ARG_W(32), .CNT_W(8), .TIMEOUT(32'd40)) dut (
    .__clk      (clk),
    .__resetn   (resetn),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_arg    (req_arg),
    .req_count  (req_count),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_cycles (rsp_cycles),
    .rsp_calls  (rsp_calls),
    .rsp_timeout(rsp_timeout),
    .tick       (tick),
    .__c_start  (c_start),
    .__c_p_ms   (c_p_ms),
    .__c_valid  (c_valid),
    .__c_idle   (c_idle)
  );

  // ms-sleep callee: done pulse arg*div cycles after the cycle following start.
  // It has no reset of its own, so it keeps running across a DUT reset.
  logic        cal_busy  = 1'b0;
  logic        cal_valid = 1'b0;
  int unsigned cal_cnt   = 0;
  int unsigned cal_div   = 10;

  always @(posedge clk) begin
    cal_valid <= 1'b0;
    if (cal_busy) begin
      if (cal_cnt == 0) begin
        cal_valid <= 1'b1;
        cal_busy  <= 1'b0;
      end else begin
        cal_cnt <= cal_cnt - 1;
      end
    end else if (c_start) begin
      if (c_p_ms * cal_div == 0) begin
        cal_valid <= 1'b1;
      end else begin
        cal_busy <= 1'b1;
        cal_cnt  <= c_p_ms * cal_div - 1;
      end
    end
  end
  assign c_valid = cal_valid;
  assign c_idle  = ~cal_busy;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d", nm, act, act, exp);
    end
  endtask

  // Run-level model: each call costs arg*div+1 cycles and completes only if
  // that does not exceed the timeout; the first over-long call ends the run.
  task automatic model(input int unsigned arg, input int unsigned div, input int unsigned cnt,
                       output logic [31:0] cyc, output int unsigned calls, output bit to);
    longint unsigned acc;
    longint unsigned lat;
    acc   = 0;
    lat   = longint'(arg) * longint'(div) + 1;
    calls = 0;
    to    = 1'b0;
    for (int unsigned i = 0; i < cnt; i++) begin
      if (TO == 0 || lat <= TO) begin
        acc = acc + lat;
        if (acc > 64'hFFFF_FFFF) acc = 64'hFFFF_FFFF;
        calls++;
      end else begin
        to = 1'b1;
        break;
      end
    end
    cyc = acc[31:0];
  endtask

  // Per-cycle monitor state shared with the host task.
  logic        in_flight = 1'b0;
  logic [31:0] exp_arg   = '0;
  int          n_start   = 0;
  int          n_tick    = 0;
  logic        p_valid   = 1'b0;
  logic [31:0] p_cyc     = '0;
  logic [7:0]  p_calls   = '0;
  logic        p_to      = 1'b0;

  // Sample 1 time unit after each rising edge: protocol and stability checks.
  always @(posedge clk) begin
    #1;
    if (resetn) begin
      if (c_start) begin
        n_start++;
        check("start_only_when_idle", c_idle, 1);
      end
      if (tick) n_tick++;
      if (in_flight) begin
        check("p_ms_constant", c_p_ms, exp_arg);
        check("req_ready_low_busy", req_ready, 0);
      end
      if (p_valid && !rsp_ready) begin
        check("rsp_valid_held", rsp_valid, 1);
        check("rsp_cycles_stable", rsp_cycles, p_cyc);
        check("rsp_calls_stable", rsp_calls, p_calls);
        check("rsp_timeout_stable", rsp_timeout, p_to);
      end
      p_valid = rsp_valid;
      p_cyc   = rsp_cycles;
      p_calls = rsp_calls;
      p_to    = rsp_timeout;
    end else begin
      p_valid = 1'b0;
    end
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req_ready"}, req_ready, 1);
    check({tag, "_rsp_valid"}, rsp_valid, 0);
    check({tag, "_rsp_cycles"}, rsp_cycles, 0);
    check({tag, "_rsp_calls"}, rsp_calls, 0);
    check({tag, "_rsp_timeout"}, rsp_timeout, 0);
    check({tag, "_tick"}, tick, 0);
    check({tag, "_c_start"}, c_start, 0);
    check({tag, "_c_p_ms"}, c_p_ms, 0);
  endtask

  // One full request/response transaction. lit_* pin hand-computed results.
  task automatic run_req(input int unsigned arg, input int unsigned cnt, input int unsigned div,
                         input int unsigned hold, input bit use_lit,
                         input int unsigned lit_cyc, input int unsigned lit_calls, input bit lit_to);
    logic [31:0] e_cyc;
    int unsigned e_calls;
    bit          e_to;
    int unsigned waited;
    model(arg, div, cnt, e_cyc, e_calls, e_to);
    @(negedge clk);
    cal_div   = div;
    req_arg   = arg;
    req_count = cnt[7:0];
    req_valid = 1'b1;
    rsp_ready = 1'b0;
    waited = 0;
    while (!req_ready && waited < 3000) begin
      @(negedge clk);
      waited++;
    end
    if (!req_ready) begin
      check("req_accept_bound", req_ready, 1);
      req_valid = 1'b0;
      return;
    end
    @(posedge clk);
    in_flight = 1'b1;
    exp_arg   = arg;
    n_start   = 0;
    n_tick    = 0;
    @(negedge clk);
    req_valid = 1'b0;
    waited = 1;
    while (!rsp_valid && waited < 5000) begin
      @(negedge clk);
      waited++;
    end
    check("rsp_bound", rsp_valid, 1);
    if (!rsp_valid) begin
      in_flight = 1'b0;
      return;
    end
    if (cnt == 0) check("zero_count_rsp_delay", waited, 1);
    repeat (hold) @(negedge clk);
    check("rsp_cycles", rsp_cycles, e_cyc);
    check("rsp_calls", rsp_calls, e_calls);
    check("rsp_timeout", rsp_timeout, e_to);
    check("start_pulses", n_start, e_calls + (e_to ? 1 : 0));
    check("tick_pulses", n_tick, e_calls);
    if (use_lit) begin
      check("lit_rsp_cycles", rsp_cycles, lit_cyc);
      check("lit_rsp_calls", rsp_calls, lit_calls);
      check("lit_rsp_timeout", rsp_timeout, lit_to);
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    in_flight = 1'b0;
    #1;
    check("rsp_valid_dropped", rsp_valid, 0);
    check("req_ready_after_rsp", req_ready, 1);
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned waited;
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    resetn = 1'b1;
    repeat (2) @(negedge clk);

    // Directed runs with hand-computed results.
    run_req(3, 1, 10, 10, 1'b1, 31, 1, 1'b0);
    run_req(0, 4, 10, 0, 1'b1, 4, 4, 1'b0);
    run_req(7, 0, 10, 2, 1'b1, 0, 0, 1'b0);
    run_req(5, 3, 10, 1, 1'b1, 0, 0, 1'b1);
    run_req(0, 1, 10, 0, 1'b1, 1, 1, 1'b0);
    run_req(3, 2, 13, 0, 1'b1, 80, 2, 1'b0);
    run_req(4, 2, 10, 0, 1'b1, 0, 0, 1'b1);

    // Reset asserted in the middle of a call.
    @(negedge clk);
    cal_div   = 10;
    req_arg   = 5;
    req_count = 8'd2;
    req_valid = 1'b1;
    waited = 0;
    while (!req_ready && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    check("rst_test_accept", req_ready, 1);
    @(negedge clk);
    req_valid = 1'b0;
    waited = 0;
    while (!c_start && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    check("rst_test_start_seen", c_start, 1);
    repeat (5) @(negedge clk);
    #2;
    resetn = 1'b0;
    #1;
    check_reset_outputs("async_reset");
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    repeat (3) @(negedge clk);
    check("post_reset_no_rsp", rsp_valid, 0);
    check("post_reset_req_ready", req_ready, 1);

    // Randomised runs against the model.
    for (int k = 0; k < 14; k++) begin
      run_req($urandom_range(0, 5), $urandom_range(0, 4), $urandom_range(1, 12),
              $urandom_range(0, 4), 1'b0, 0, 0, 1'b0);
    end

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/nonstd_caller.md
Name: nonstd_caller

Overview:
- Initiator for the nonstd call handshake: drives `__start`/argument into a callee such as the ms-sleep function, then waits on the callee's `__valid`/`__idle`.
- A host issues one request (argument plus repeat count). The block issues the calls back-to-back and measures total callee latency in clock cycles.
- Each call has its own timeout.
- Used as the timing and sequencing front end for blink/delay style designs, and as a latency probe for nonstd callees.

Parameters:
- ARG_W, 32, width of the callee argument (`__c_p_ms`).
- CNT_W, 8, width of the repeat count.
- TIMEOUT, 32'hFFFF_FFFF, maximum cycles per call in WAIT before abort; 0 disables the timeout.

Ports:
- `__clk`  in  1  clock.
- `__resetn`  in  1  asynchronous active-low reset.
- `req_valid`  in  1  host request valid.
- `req_ready`  out  1  block can accept a request (high only in IDLE).
- `req_arg`  in  ARG_W  argument passed to every call.
- `req_count`  in  CNT_W  number of calls to issue.
- `rsp_valid`  out  1  response valid, held until accepted.
- `rsp_ready`  in  1  host accepts the response.
- `rsp_cycles`  out  32  total callee latency summed over completed calls, saturating.
- `rsp_calls`  out  CNT_W  number of calls completed.
- `rsp_timeout`  out  1  the run was aborted by a timeout.
- `tick`  out  1  one-cycle pulse per completed call.
- `__c_start`  out  1  callee start.
- `__c_p_ms`  out  ARG_W  callee argument.
- `__c_valid`  in  1  callee done pulse.
- `__c_idle`  in  1  callee idle.

Behaviour:
- Reset (async, `__resetn`=0):
  - state = IDLE.
  - `req_ready`=1, `rsp_valid`=0, `rsp_cycles`=0, `rsp_calls`=0, `rsp_timeout`=0, `tick`=0, `__c_start`=0, `__c_p_ms`=0.
  - Internal counters clear.
  - Reset mid-call drops the call with no response; the callee is not reset by this block.
- All outputs are registered.
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - On `req_valid` && `req_ready`, latch `req_arg` into `__c_p_ms` and `req_count` into `remaining`.
  - Clear `rsp_cycles`, `rsp_calls` and `rsp_timeout`.
  - If `req_count`==0, go to RESP (`rsp_calls`=0, `rsp_cycles`=0); otherwise go to ISSUE.
  - `req_ready` is 0 outside IDLE.
- ISSUE:
  - Wait until `__c_idle`==1, then assert `__c_start` for exactly one cycle, the cycle in which the callee samples it.
  - Clear `lat`=0 and go to WAIT.
  - `__c_valid` is ignored in ISSUE, so a stale done from an aborted call is discarded.
- WAIT:
  - `lat` increments every cycle.
  - Latency is the number of clock edges from the edge that samples `__c_start` up to and including the first cycle `__c_valid`=1.
  - A callee that raises valid on the cycle after start has latency 1.
  - On `__c_valid`:
    - `rsp_cycles` += latency, saturating at 32'hFFFF_FFFF.
    - `rsp_calls` += 1.
    - `tick` pulses on the next cycle.
    - `remaining` -= 1.
    - Go to ISSUE if `remaining` != 0, else go to RESP.
  - Timeout: if TIMEOUT != 0 and `lat` reaches TIMEOUT with no valid, set `rsp_timeout`=1 and go to RESP. The callee is left running.
  - If timeout and valid coincide in the same cycle, valid wins and the call counts as completed.
- RESP:
  - `rsp_valid`=1 and all `rsp_*` outputs are stable.
  - On `rsp_ready`, `rsp_valid`=0 and go to IDLE, where `req_ready`=1 on the next cycle.
  - A new request is never accepted in the same cycle as a response handshake.
- Back-to-back calls: at least one ISSUE cycle sits between a callee valid and the next start. Start is never asserted while `__c_idle`=0.
- `__c_p_ms` is constant from acceptance to RESP.

Test Plan:
- Callee = ms-sleep with DIVISOR=10, `req_arg`=3, `req_count`=1:
  - One `__c_start` pulse, with `__c_p_ms`=3 throughout.
  - `rsp_cycles`=31, `rsp_calls`=1, `rsp_timeout`=0, one `tick` pulse.
- Same callee, `req_arg`=0, `req_count`=4:
  - Four start pulses, each issued only after the callee returns to idle.
  - `rsp_cycles`=4, `rsp_calls`=4, 4 tick pulses.
- `req_count`=0: no `__c_start`; `rsp_valid` occurs 1 cycle after acceptance with `rsp_calls`=0 and `rsp_cycles`=0.
- TIMEOUT=20, `req_arg`=5, DIVISOR=10, `req_count`=3:
  - After 20 WAIT cycles, `rsp_timeout`=1, `rsp_calls`=0, `rsp_cycles`=0.
  - The next request's start is held until the callee's late valid/idle returns.
  - The stale valid is not counted.
- `rsp_ready` held low for 10 cycles: `rsp_valid` and all `rsp_*` outputs stay stable, and `req_ready` stays 0 until the handshake completes.
- `__resetn` pulsed low during WAIT: all outputs go to their reset values immediately (asynchronously), no response is produced, and `req_ready`=1 after release.
